tx_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the single AXIS slave input of the 10G TX MAC among `NUM_PORTS` upstream frame sources. It grants one source at a time and holds the grant until that frame's `tlast` beat is accepted. It also truncates runaway frames at `MAX_BEATS` and honours a pause request at frame boundaries. It sits directly in front of the TX MAC on `tx_clk`.

---
 rtl/eth_tx_pkg.sv | 26 ++
 rtl/tx_frame_arbiter_rr_pick.sv | 29 ++
 rtl/tx_frame_arbiter.sv | 145 ++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants for the 10G TX path: frame limits, arbiter state encoding,
// and a small one-hot helper.
package eth_tx_pkg;

  localparam int ETH_MAX_FRAME_BYTES = 1518;
  localparam int ETH_BUS_BYTES       = 4;
  // A partial last word still costs a full beat, so round up.
  localparam int ETH_MAX_BEATS       = (ETH_MAX_FRAME_BYTES + ETH_BUS_BYTES - 1) / ETH_BUS_BYTES;
  localparam int TRUNC_CNT_W         = 16;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FWD   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after i_last_grant,
// wrapping around; returns a one-hot grant and a valid flag.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    // i == NUM_PORTS lands back on the last winner, so it only wins when alone.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = IDX_W'((int'(i_last_grant) + i) % NUM_PORTS);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the TX MAC. Holds a grant for a
// whole frame, cuts runaway frames at MAX_BEATS and discards their tail.
module tx_frame_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int MAX_BEATS       = ETH_MAX_BEATS
) (
  input  logic                                   tx_clk,
  input  logic                                   tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   in_slave_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0]   in_slave_tkeep,
  input  logic [NUM_PORTS-1:0]                   in_slave_tvalid,
  input  logic [NUM_PORTS-1:0]                   in_slave_tlast,
  output logic [NUM_PORTS-1:0]                   out_slave_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             out_master_tdata,
  output logic [AXIS_DATA_BYTES-1:0]             out_master_tkeep,
  output logic                                   out_master_tvalid,
  output logic                                   out_master_tlast,
  input  logic                                   in_master_tready,
  input  logic                                   in_pause,
  output logic [NUM_PORTS-1:0]                   out_grant,
  output logic                                   out_trunc_pulse,
  output logic [TRUNC_CNT_W-1:0]                 out_trunc_count
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  arb_state_t              r_state;
  logic [NUM_PORTS-1:0]    r_grant;
  logic [IDX_W-1:0]        r_last_grant;
  logic [BEAT_W-1:0]       r_beat_cnt;
  logic [TRUNC_CNT_W-1:0]  r_trunc_count;

  logic [NUM_PORTS-1:0]       w_pick_grant;
  logic                       w_pick_valid;
  logic [2:0]                 w_pick_idx_full;
  logic [IDX_W-1:0]           w_pick_idx;
  logic [AXIS_DATA_WIDTH-1:0] w_src_tdata;
  logic [AXIS_DATA_BYTES-1:0] w_src_tkeep;
  logic                       w_src_tvalid;
  logic                       w_src_tlast;
  logic                       w_force_last;
  logic                       w_fwd_accept;
  logic                       w_drain_accept;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .i_req        (in_slave_tvalid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_grant),
    .o_valid      (w_pick_valid)
  );

  assign w_pick_idx_full = onehot_to_idx(8'(w_pick_grant));
  assign w_pick_idx      = w_pick_idx_full[IDX_W-1:0];

  // r_last_grant doubles as the index of the source currently being served.
  assign w_src_tdata  = in_slave_tdata[int'(r_last_grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign w_src_tkeep  = in_slave_tkeep[int'(r_last_grant)*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
  assign w_src_tvalid = in_slave_tvalid[r_last_grant];
  assign w_src_tlast  = in_slave_tlast[r_last_grant];

  assign w_force_last   = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign w_fwd_accept   = (r_state == ST_FWD) && w_src_tvalid && in_master_tready;
  assign w_drain_accept = (r_state == ST_DRAIN) && w_src_tvalid;

  assign out_trunc_pulse = w_fwd_accept && w_force_last && !w_src_tlast;
  assign out_grant       = r_grant;
  assign out_trunc_count = r_trunc_count;

  always_comb begin
    out_master_tdata  = '0;
    out_master_tkeep  = '0;
    out_master_tvalid = 1'b0;
    out_master_tlast  = 1'b0;
    out_slave_tready  = '0;
    case (r_state)
      ST_FWD: begin
        out_master_tdata  = w_src_tdata;
        out_master_tkeep  = w_src_tkeep;
        out_master_tvalid = w_src_tvalid;
        out_master_tlast  = w_src_tlast || w_force_last;
        out_slave_tready  = r_grant & {NUM_PORTS{in_master_tready}};
      end
      ST_DRAIN: begin
        out_slave_tready  = r_grant;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(NUM_PORTS - 1);
      r_beat_cnt    <= '0;
      r_trunc_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (!in_pause && w_pick_valid) begin
            r_grant      <= w_pick_grant;
            r_last_grant <= w_pick_idx;
            r_state      <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (w_fwd_accept) begin
            if (w_src_tlast) begin
              r_state    <= ST_IDLE;
              r_grant    <= '0;
              r_beat_cnt <= '0;
            end else if (w_force_last) begin
              r_state    <= ST_DRAIN;
              r_beat_cnt <= '0;
              if (r_trunc_count != '1) r_trunc_count <= r_trunc_count + 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_accept && w_src_tlast) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized bench for tx_frame_arbiter: per-source frame queues, a
// frame-level round-robin reference model, and a scoreboarding monitor.
module tb_tx_frame_arbiter;

  localparam int NP   = 4;
  localparam int W    = 32;
  localparam int KB   = W / 8;
  localparam int MAXB = 380;
  localparam int HALF = 10;

  logic              tx_clk = 1'b0;
  logic              tx_rst;
  logic [NP*W-1:0]   in_slave_tdata;
  logic [NP*KB-1:0]  in_slave_tkeep;
  logic [NP-1:0]     in_slave_tvalid;
  logic [NP-1:0]     in_slave_tlast;
  logic [NP-1:0]     out_slave_tready;
  logic [W-1:0]      out_master_tdata;
  logic [KB-1:0]     out_master_tkeep;
  logic              out_master_tvalid;
  logic              out_master_tlast;
  logic              in_master_tready;
  logic              in_pause;
  logic [NP-1:0]     out_grant;
  logic              out_trunc_pulse;
  logic [15:0]       out_trunc_count;

  always #HALF tx_clk = ~tx_clk;

  tx_frame_arbiter #(
    .NUM_PORTS       (NP),
    .AXIS_DATA_WIDTH (W),
    .AXIS_DATA_BYTES (KB),
    .MAX_BEATS       (MAXB)
  ) dut (
    .tx_clk            (tx_clk),
    .tx_rst            (tx_rst),
    .in_slave_tdata    (in_slave_tdata),
    .in_slave_tkeep    (in_slave_tkeep),
    .in_slave_tvalid   (in_slave_tvalid),
    .in_slave_tlast    (in_slave_tlast),
    .out_slave_tready  (out_slave_tready),
    .out_master_tdata  (out_master_tdata),
    .out_master_tkeep  (out_master_tkeep),
    .out_master_tvalid (out_master_tvalid),
    .out_master_tlast  (out_master_tlast),
    .in_master_tready  (in_master_tready),
    .in_pause          (in_pause),
    .out_grant         (out_grant),
    .out_trunc_pulse   (out_trunc_pulse),
    .out_trunc_count   (out_trunc_count)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [KB-1:0] keep;
    logic          last;
    logic          trunc;
  } beat_t;

  beat_t pq[NP][$];
  int    flen[NP][$];
  beat_t exp_q[$];
  int    exp_g[$];
  int    exp_trunc;
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    mon_en = 0;
  bit    force_ready = 0;
  bit    pause_en = 0;
  bit    at_start[NP];
  logic [NP-1:0] fire_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic gen_frame(input int k, input int len);
    beat_t b;
    flen[k].push_back(len);
    for (int i = 0; i < len; i++) begin
      b.data  = {4'(k), 4'(flen[k].size()), 8'(i), 16'($urandom)};
      b.keep  = 4'($urandom_range(1, 15));
      b.last  = (i == len - 1);
      b.trunc = 1'b0;
      pq[k].push_back(b);
    end
  endtask

  // Frame-level reference: serve pending frames round-robin starting after
  // port NP-1, clip each to MAXB beats with a forced last.
  task automatic build_expected();
    int cur[NP];
    int fi[NP];
    int last_p, found, p, len;
    beat_t ob;
    exp_q.delete();
    exp_g.delete();
    exp_trunc = 0;
    for (int k = 0; k < NP; k++) begin
      cur[k] = 0;
      fi[k]  = 0;
    end
    last_p = NP - 1;
    forever begin
      found = -1;
      for (int i = 1; i <= NP; i++) begin
        p = (last_p + i) % NP;
        if (found < 0 && fi[p] < flen[p].size()) found = p;
      end
      if (found < 0) break;
      len = flen[found][fi[found]];
      exp_g.push_back(found);
      for (int b = 0; b < len && b < MAXB; b++) begin
        ob       = pq[found][cur[found] + b];
        ob.last  = (b == len - 1) || (b == MAXB - 1);
        ob.trunc = (b == MAXB - 1) && (len > MAXB);
        exp_q.push_back(ob);
      end
      if (len > MAXB) exp_trunc++;
      cur[found] += len;
      fi[found]++;
      last_p = found;
    end
  endtask

  function automatic bit all_sent();
    bit e;
    e = (exp_q.size() == 0);
    for (int k = 0; k < NP; k++) if (pq[k].size() != 0) e = 0;
    return e;
  endfunction

  task automatic wait_done(input int limit, input string name);
    int cyc;
    cyc = 0;
    while (!all_sent() && cyc < limit) begin
      @(negedge tx_clk);
      #6;
      cyc++;
    end
    if (!all_sent()) flag_fail(name, exp_q.size(), 0);
  endtask

  // Source drivers: first beat of a frame is always valid, later beats may bubble.
  initial begin
    beat_t b;
    in_slave_tdata   = '0;
    in_slave_tkeep   = '0;
    in_slave_tvalid  = '0;
    in_slave_tlast   = '0;
    in_master_tready = 1'b0;
    in_pause         = 1'b0;
    fire_s           = '0;
    for (int k = 0; k < NP; k++) at_start[k] = 1;
    forever begin
      @(negedge tx_clk);
      for (int k = 0; k < NP; k++) begin
        if (fire_s[k] && pq[k].size() > 0) begin
          b = pq[k].pop_front();
          at_start[k] = b.last;
        end
      end
      for (int k = 0; k < NP; k++) begin
        if (pq[k].size() > 0) begin
          in_slave_tvalid[k]       = at_start[k] ? 1'b1 : ($urandom_range(0, 3) != 0);
          in_slave_tdata[k*W +: W] = pq[k][0].data;
          in_slave_tkeep[k*KB +: KB] = pq[k][0].keep;
          in_slave_tlast[k]        = pq[k][0].last;
        end else begin
          in_slave_tvalid[k]       = 1'b0;
          in_slave_tdata[k*W +: W] = '0;
          in_slave_tkeep[k*KB +: KB] = '0;
          in_slave_tlast[k]        = 1'b0;
        end
      end
      in_master_tready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!pause_en) in_pause = 1'b0;
      else if ($urandom_range(0, 15) == 0) in_pause = ~in_pause;
      #4;
      fire_s = in_slave_tvalid & out_slave_tready;
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    bit pv, ppause, preq, pend, fire;
    logic [NP-1:0] pg, g;
    beat_t e;
    pv = 0; ppause = 0; preq = 0; pend = 0; pg = '0;
    forever begin
      @(negedge tx_clk);
      #4;
      if (!mon_en) begin
        pv = 0;
        continue;
      end
      g    = out_grant;
      fire = out_master_tvalid && in_master_tready;
      if (pv) begin
        if (pg == '0 && g != '0) begin
          if (exp_g.size() == 0) flag_fail("grant_extra", int'(g), 0);
          else chk("grant_order", 64'(g), 64'(1) << exp_g.pop_front());
        end
        if (pg == '0 && ppause) chk("pause_hold", 64'(g), 64'(0));
        else if (pg == '0 && preq) chk("grant_latency", 64'(g != '0), 64'(1));
        if (pg != '0 && g != pg) chk("frame_gap", 64'(g), 64'(0));
        if (pend) chk("idle_after_last", 64'(g), 64'(0));
      end
      if (out_master_tvalid)
        chk("tready_mirror", 64'(out_slave_tready), 64'(in_master_tready ? g : '0));
      pend = 0;
      if (fire) begin
        if (exp_q.size() == 0) flag_fail("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(out_master_tdata), 64'(e.data));
          chk("beat_keep", 64'(out_master_tkeep), 64'(e.keep));
          chk("beat_last", 64'(out_master_tlast), 64'(e.last));
          chk("trunc_pulse", 64'(out_trunc_pulse), 64'(e.trunc));
          pend = e.last && !e.trunc;
        end
      end else if (out_trunc_pulse) begin
        flag_fail("trunc_spurious", 1, 0);
      end
      pg     = g;
      ppause = in_pause;
      preq   = |in_slave_tvalid;
      pv     = 1;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},  64'(out_grant),         64'(0));
    chk({tag, "_sready"}, 64'(out_slave_tready),  64'(0));
    chk({tag, "_mvalid"}, 64'(out_master_tvalid), 64'(0));
    chk({tag, "_mlast"},  64'(out_master_tlast),  64'(0));
    chk({tag, "_mdata"},  64'(out_master_tdata),  64'(0));
    chk({tag, "_mkeep"},  64'(out_master_tkeep),  64'(0));
    chk({tag, "_pulse"},  64'(out_trunc_pulse),   64'(0));
    chk({tag, "_tcount"}, 64'(out_trunc_count),   64'(0));
  endtask

  initial begin
    int nf;
    tx_rst = 1'b1;
    repeat (3) @(negedge tx_clk);
    #4;
    chk_reset_outputs("rst");

    // Random traffic with runaway frames, a 380-beat boundary frame and pauses.
    @(negedge tx_clk);
    #2;
    for (int k = 0; k < NP; k++) begin
      gen_frame(k, $urandom_range(1, 20));
      if (k == 0) gen_frame(0, MAXB + 1);
      if (k == 1) gen_frame(1, 400);
      if (k == 3) gen_frame(3, MAXB);
      repeat ($urandom_range(2, 3)) gen_frame(k, $urandom_range(1, 20));
    end
    build_expected();
    pause_en    = 1;
    force_ready = 0;
    @(negedge tx_clk);
    #1;
    tx_rst = 1'b0;
    mon_en = 1;
    wait_done(60000, "random_timeout");
    pause_en = 0;
    repeat (3) @(negedge tx_clk);
    #6;
    chk("trunc_count", 64'(out_trunc_count), 64'(exp_trunc));
    chk("grants_left", 64'(exp_g.size()), 64'(0));
    chk("idle_grant", 64'(out_grant), 64'(0));

    // Reset in the middle of a port-2 frame, then check priority restarts at 0.
    mon_en      = 0;
    force_ready = 1;
    @(negedge tx_clk);
    #2;
    for (int k = 0; k < NP; k++) flen[k].delete();
    gen_frame(2, 20);
    nf = 0;
    for (int c = 0; c < 200 && nf < 5; c++) begin
      @(negedge tx_clk);
      #4;
      if (out_master_tvalid && in_master_tready) nf++;
    end
    chk("mid_frame_beats", 64'(nf), 64'(5));
    @(negedge tx_clk);
    #1;
    tx_rst = 1'b1;
    @(negedge tx_clk);
    #2;
    chk_reset_outputs("midrst");
    for (int k = 0; k < NP; k++) begin
      pq[k].delete();
      flen[k].delete();
      at_start[k] = 1;
    end
    gen_frame(3, 3);
    gen_frame(0, 2);
    build_expected();
    @(negedge tx_clk);
    #1;
    tx_rst = 1'b0;
    mon_en = 1;
    wait_done(2000, "post_reset_timeout");
    repeat (3) @(negedge tx_clk);
    #6;
    chk("post_reset_grants_left", 64'(exp_g.size()), 64'(0));
    chk("post_reset_idle", 64'(out_grant), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
